// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, fetches over req/ack, holds the word while IF/ID is frozen.
// Zero-wait ack presents in the request cycle; a redirect with a fetch in flight drops that stale word.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        memStall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_q, old_d;
  logic [31:0] buf_q, buf_d;
  logic        advance, redirect, ack;

  assign advance  = !stall_i && !memStall_i;
  assign redirect = branch_i && advance;

  // Request is masked during reset so a late ack from before reset is ignored.
  assign imem_req_o  = !rst_i && ((state_q == REQ) || (state_q == DISCARD));
  assign imem_addr_o = (state_q == DISCARD) ? old_q : pc_q;
  assign ack         = imem_req_o && imem_ack_i;
  assign pc_o        = rst_i ? RESET_PC : pc_q;

  always_comb begin
    valid_o       = 1'b0;
    instruction_o = 32'h0;
    if (!rst_i) begin
      if ((state_q == REQ) && ack) begin
        valid_o       = 1'b1;
        instruction_o = imem_data_i;
      end else if (state_q == HOLD) begin
        valid_o       = 1'b1;
        instruction_o = buf_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    old_d   = old_q;
    buf_d   = buf_q;
    case (state_q)
      REQ: begin
        if (redirect && !ack) begin
          old_d   = pc_q;
          pc_d    = branch_target_i;
          state_d = DISCARD;
        end else if (redirect) begin
          pc_d = branch_target_i;
        end else if (ack && advance) begin
          pc_d = pc_q + PC_STEP;
        end else if (ack) begin
          buf_d   = imem_data_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = branch_target_i;
          state_d = REQ;
        end else if (advance) begin
          pc_d    = pc_q + PC_STEP;
          state_d = REQ;
        end
      end
      DISCARD: begin
        // The stale word is dropped; the latest redirect target is what gets fetched next.
        if (redirect) pc_d = branch_target_i;
        if (ack) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      old_q   <= RESET_PC;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      old_q   <= old_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: instruction memory with configurable ack latency,
// expected fetch stream kept in a queue and popped as IF/ID would capture it.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        memStall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instruction_o;
  logic        valid_o;

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 0;
  int wait_cnt = 0;
  bit ack_force = 1'b0;
  bit rst_next = 1'b1;
  logic [31:0] force_data = 32'h0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  instr_fetch_unit dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .memStall_i(memStall_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .pc_o(pc_o), .instruction_o(instruction_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h00A0_0093;
    if (a == 32'h8) return 32'hDEAD_BEEF;
    return a ^ 32'h1357_0000;
  endfunction

  // One clock cycle: drive controls after the falling edge, let the memory answer, sample at negedge+2.
  task automatic step(input logic st, input logic ms, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst_i = rst_next;
    stall_i = st; memStall_i = ms; branch_i = br; branch_target_i = tgt;
    #1;
    if (ack_force) begin
      imem_ack_i = 1'b1; imem_data_i = force_data;
    end else if (imem_req_o) begin
      if (wait_cnt >= lat) begin
        imem_ack_i = 1'b1; imem_data_i = mem_word(imem_addr_o); wait_cnt = 0;
      end else begin
        imem_ack_i = 1'b0; imem_data_i = 32'hFFFF_FFFF; wait_cnt++;
      end
    end else begin
      imem_ack_i = 1'b0; imem_data_i = 32'hFFFF_FFFF; wait_cnt = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_next = 1'b1;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    rst_next = 1'b0;
    ack_force = 1'b0;
    wait_cnt = 0;
  endtask

  task automatic test_reset();
    lat = 0;
    rst_next = 1'b1; ack_force = 1'b1; force_data = 32'h1234_5678;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_cmp++; if (instruction_o !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instruction_o); end
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc_o); end
    ack_force = 1'b0; rst_next = 1'b0; lat = 3;
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_first_req: got req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_zero_wait();
    int pops;
    lat = 0; do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    pops = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0);
      if (valid_o && exp_q.size() > 0) begin
        exp_pc = exp_q.pop_front(); pops++;
        n_cmp++; if (imem_addr_o !== exp_pc || imem_req_o !== 1'b1) begin n_bad++; $display("FAIL t1_addr: got %h want %h", imem_addr_o, exp_pc); end
        n_cmp++; if (pc_o !== exp_pc) begin n_bad++; $display("FAIL t1_pc: got %h want %h", pc_o, exp_pc); end
        n_cmp++; if (instruction_o !== mem_word(exp_pc)) begin n_bad++; $display("FAIL t1_instr: got %h want %h", instruction_o, mem_word(exp_pc)); end
      end
    end
    n_cmp++; if (pops !== 3) begin n_bad++; $display("FAIL t1_count: got %0d want 3", pops); end
    exp_q.delete();
  endtask

  task automatic test_wait_states();
    lat = 2; do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0);
      n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_bad++; $display("FAIL t2_hold_addr[%0d]: got req=%b addr=%h want req=1 addr=0", i, imem_req_o, imem_addr_o); end
      if (i < 2) begin
        n_cmp++; if (valid_o !== 1'b0 || instruction_o !== 32'h0) begin n_bad++; $display("FAIL t2_bubble[%0d]: got v=%b i=%h want v=0 i=0", i, valid_o, instruction_o); end
      end else begin
        n_cmp++; if (valid_o !== 1'b1 || instruction_o !== mem_word(32'h0)) begin n_bad++; $display("FAIL t2_data: got v=%b i=%h want v=1 i=%h", valid_o, instruction_o, mem_word(32'h0)); end
      end
    end
  endtask

  task automatic test_stall_hold();
    lat = 0; do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    step(0, 0, 0, 32'h0);
    if (valid_o) exp_pc = exp_q.pop_front();
    step(1, 0, 0, 32'h0);
    n_cmp++; if (valid_o !== 1'b1 || instruction_o !== 32'h00A0_0093) begin n_bad++; $display("FAIL t3_ack: got v=%b i=%h want v=1 i=00a00093", valid_o, instruction_o); end
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 32'h0);
      n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL t3_req[%0d]: got %b want 0", i, imem_req_o); end
      n_cmp++; if (valid_o !== 1'b1 || instruction_o !== 32'h00A0_0093 || pc_o !== 32'h4) begin n_bad++; $display("FAIL t3_hold[%0d]: got v=%b i=%h pc=%h want v=1 i=00a00093 pc=4", i, valid_o, instruction_o, pc_o); end
    end
    step(0, 0, 0, 32'h0);
    if (valid_o && exp_q.size() > 0) begin
      exp_pc = exp_q.pop_front();
      n_cmp++; if (pc_o !== exp_pc || instruction_o !== mem_word(exp_pc)) begin n_bad++; $display("FAIL t3_release: got pc=%h i=%h want pc=%h i=%h", pc_o, instruction_o, exp_pc, mem_word(exp_pc)); end
    end else begin
      n_cmp++; n_bad++; $display("FAIL t3_release: got valid=%b want 1", valid_o);
    end
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin n_bad++; $display("FAIL t3_next: got req=%b addr=%h want req=1 addr=8", imem_req_o, imem_addr_o); end
    exp_q.delete();
  endtask

  task automatic test_branch_discard();
    lat = 0; do_reset();
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    lat = 2; wait_cnt = 0;
    step(0, 0, 1, 32'h100);
    n_cmp++; if (imem_addr_o !== 32'h8 || valid_o !== 1'b0) begin n_bad++; $display("FAIL t4_br: got addr=%h v=%b want addr=8 v=0", imem_addr_o, valid_o); end
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || valid_o !== 1'b0) begin n_bad++; $display("FAIL t4_held: got req=%b addr=%h v=%b want req=1 addr=8 v=0", imem_req_o, imem_addr_o, valid_o); end
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_ack_i !== 1'b1 || valid_o !== 1'b0 || instruction_o !== 32'h0) begin n_bad++; $display("FAIL t4_stale: got ack=%b v=%b i=%h want ack=1 v=0 i=0", imem_ack_i, valid_o, instruction_o); end
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_bad++; $display("FAIL t4_target: got req=%b addr=%h want req=1 addr=100", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_branch_with_ack();
    lat = 0; do_reset();
    step(0, 0, 0, 32'h0);
    step(0, 0, 1, 32'h200);
    n_cmp++; if (valid_o !== 1'b1 || instruction_o !== mem_word(32'h4)) begin n_bad++; $display("FAIL t5_ack: got v=%b i=%h want v=1 i=%h", valid_o, instruction_o, mem_word(32'h4)); end
    step(0, 1, 1, 32'h300);
    n_cmp++; if (imem_addr_o !== 32'h200 || pc_o !== 32'h200) begin n_bad++; $display("FAIL t5_redir: got addr=%h pc=%h want 200", imem_addr_o, pc_o); end
    step(0, 1, 1, 32'h300);
    n_cmp++; if (imem_req_o !== 1'b0 || pc_o !== 32'h200 || valid_o !== 1'b1) begin n_bad++; $display("FAIL t5_frozen: got req=%b pc=%h v=%b want req=0 pc=200 v=1", imem_req_o, pc_o, valid_o); end
    step(0, 0, 1, 32'h300);
    n_cmp++; if (instruction_o !== mem_word(32'h200)) begin n_bad++; $display("FAIL t5_held_word: got %h want %h", instruction_o, mem_word(32'h200)); end
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin n_bad++; $display("FAIL t5_release: got req=%b addr=%h want req=1 addr=300", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_reset_in_discard();
    lat = 0; do_reset();
    step(0, 0, 0, 32'h0);
    lat = 2; wait_cnt = 0;
    step(0, 0, 1, 32'h100);
    step(0, 0, 0, 32'h0);
    rst_next = 1'b1; ack_force = 1'b1; force_data = 32'hBAD0_0001;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 32'h0);
      n_cmp++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || instruction_o !== 32'h0) begin n_bad++; $display("FAIL t6_rst[%0d]: got req=%b v=%b i=%h want 0/0/0", i, imem_req_o, valid_o, instruction_o); end
    end
    rst_next = 1'b0; ack_force = 1'b0; lat = 0; wait_cnt = 0;
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin n_bad++; $display("FAIL t6_restart: got addr=%h pc=%h want 0", imem_addr_o, pc_o); end
    n_cmp++; if (valid_o !== 1'b1 || instruction_o !== mem_word(32'h0)) begin n_bad++; $display("FAIL t6_fresh: got v=%b i=%h want v=1 i=%h", valid_o, instruction_o, mem_word(32'h0)); end
  endtask

  task automatic test_pc_wrap();
    lat = 0; do_reset();
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr_o !== 32'hFFFF_FFFC || valid_o !== 1'b1) begin n_bad++; $display("FAIL wrap_top: got addr=%h v=%b want fffffffc v=1", imem_addr_o, valid_o); end
    step(0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr_o !== 32'h0 || pc_o !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got addr=%h pc=%h want 0", imem_addr_o, pc_o); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_branch_discard();
    test_branch_with_ack();
    test_reset_in_discard();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
